// File: rtl/execute_stage.sv
// Execute stage of the 64-bit pipeline: ALU, shifter, NZCV flags and the EX/MEM output register.
// Optional macro EX_MUL_EN builds the iterative 64-cycle shift-add multiplier and its stall FSM.
module execute_stage (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   input  logic [63:0] ReadData1ID,
   input  logic [63:0] ReadData2ID,
   input  logic [63:0] ImmID,
   input  logic        ALUSrcID,
   input  logic [3:0]  ALUOpID,
   input  logic [5:0]  ShamtID,
   input  logic        SetFlagsID,
   input  logic [63:0] PCPlus4ID,
   input  logic        LinkerRegID,
   input  logic        MemToRegID,
   input  logic        RegWriteID,
   input  logic        MemWriteID,
   input  logic        MemReadID,
   input  logic [4:0]  WriteRegID,
   output logic        stall_out,
   output logic [63:0] ALUResultEx,
   output logic [63:0] RdData2ForMem,
   output logic [63:0] LinkerRegisterDataEX,
   output logic        LinkerRegEX,
   output logic        MemToRegEX,
   output logic        RegWriteRegisterEX,
   output logic        MemWriteRegisterEX,
   output logic        MemReadRegisterEX,
   output logic [4:0]  WriteRegEX,
   output logic [3:0]  FlagsEX
);

   localparam logic [3:0] OP_PASSB = 4'b0000;
   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_SUB   = 4'b0010;
   localparam logic [3:0] OP_AND   = 4'b0011;
   localparam logic [3:0] OP_ORR   = 4'b0100;
   localparam logic [3:0] OP_EOR   = 4'b0101;
   localparam logic [3:0] OP_LSL   = 4'b0110;
   localparam logic [3:0] OP_LSR   = 4'b0111;

   logic [63:0] opB_s;
   logic [64:0] sum_s;
   logic [63:0] diff_s;
   logic [63:0] aluResult_s;
   logic        accept_s;
   logic        isMul_s;
   logic [3:0]  nextFlags_s;
   logic [63:0] nextResult_s;
   logic [63:0] nextData2_s;
   logic [63:0] nextLink_s;
   logic [4:0]  nextCtl_s;
   logic [4:0]  nextWreg_s;
   logic [4:0]  ctlIn_s;

   assign opB_s   = ALUSrcID ? ImmID : ReadData2ID;
   assign sum_s   = {1'b0, ReadData1ID} + {1'b0, opB_s};
   assign diff_s  = ReadData1ID - opB_s;
   assign ctlIn_s = {LinkerRegID, MemToRegID, RegWriteID, MemWriteID, MemReadID};

`ifdef EX_MUL_EN
   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;
   state_t      state_r, nextState_s;
   logic [5:0]  cnt_r;
   logic [63:0] mcand_r, mplier_r, acc_r, accNext_s;
   logic [63:0] mulData2_r, mulLink_r;
   logic [4:0]  mulCtl_r, mulWreg_r;

   assign isMul_s   = (ALUOpID == 4'b1000);
   assign accept_s  = in_valid && (state_r == S_IDLE);
   assign stall_out = (state_r == S_BUSY);
   assign accNext_s = acc_r + (mplier_r[0] ? mcand_r : 64'd0);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_r <= S_IDLE;
      else          state_r <= nextState_s;
   end

   // Next-state logic: leave IDLE on an accepted MUL, return after the 64th iteration.
   always_comb begin
      nextState_s = state_r;
      case (state_r)
         S_IDLE:  if (accept_s && isMul_s) nextState_s = S_BUSY; else nextState_s = S_IDLE;
         S_BUSY:  if (cnt_r == 6'd63) nextState_s = S_IDLE; else nextState_s = S_BUSY;
         default: nextState_s = S_IDLE;
      endcase
   end

   // Multiplier operand latch and shift-add iteration.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r <= 6'd0; mcand_r <= 64'd0; mplier_r <= 64'd0; acc_r <= 64'd0;
         mulData2_r <= 64'd0; mulLink_r <= 64'd0; mulCtl_r <= 5'd0; mulWreg_r <= 5'd0;
      end else if (accept_s && isMul_s) begin
         cnt_r <= 6'd0; mcand_r <= ReadData1ID; mplier_r <= opB_s; acc_r <= 64'd0;
         mulData2_r <= ReadData2ID; mulLink_r <= PCPlus4ID; mulCtl_r <= ctlIn_s; mulWreg_r <= WriteRegID;
      end else if (state_r == S_BUSY) begin
         cnt_r    <= cnt_r + 6'd1;
         acc_r    <= accNext_s;
         mcand_r  <= {mcand_r[62:0], 1'b0};
         mplier_r <= {1'b0, mplier_r[63:1]};
      end
   end
`else
   assign isMul_s   = 1'b0;
   assign accept_s  = in_valid;
   assign stall_out = 1'b0;
`endif

   // Single-cycle ALU and shifter; MUL and unused codes give zero here.
   always_comb begin
      aluResult_s = 64'd0;
      case (ALUOpID)
         OP_PASSB: aluResult_s = opB_s;
         OP_ADD:   aluResult_s = sum_s[63:0];
         OP_SUB:   aluResult_s = diff_s;
         OP_AND:   aluResult_s = ReadData1ID & opB_s;
         OP_ORR:   aluResult_s = ReadData1ID | opB_s;
         OP_EOR:   aluResult_s = ReadData1ID ^ opB_s;
         OP_LSL:   aluResult_s = ReadData1ID << ShamtID;
         OP_LSR:   aluResult_s = ReadData1ID >> ShamtID;
         default:  aluResult_s = 64'd0;
      endcase
   end

   // NZCV update; SUB carry means no borrow.
   always_comb begin
      nextFlags_s = FlagsEX;
      if (accept_s && SetFlagsID && (ALUOpID == OP_ADD))
         nextFlags_s = {sum_s[63], (sum_s[63:0] == 64'd0), sum_s[64],
                        (ReadData1ID[63] == opB_s[63]) && (sum_s[63] != ReadData1ID[63])};
      else if (accept_s && SetFlagsID && (ALUOpID == OP_SUB))
         nextFlags_s = {diff_s[63], (diff_s == 64'd0), (ReadData1ID >= opB_s),
                        (ReadData1ID[63] != opB_s[63]) && (diff_s[63] != ReadData1ID[63])};
      else
         nextFlags_s = FlagsEX;
   end

   // EX/MEM next values: a bubble unless an instruction or a finished product retires.
   always_comb begin
      nextResult_s = 64'd0;
      nextData2_s  = 64'd0;
      nextLink_s   = 64'd0;
      nextCtl_s    = 5'd0;
      nextWreg_s   = 5'd0;
`ifdef EX_MUL_EN
      if (state_r == S_BUSY) begin
         if (cnt_r == 6'd63) begin
            nextResult_s = accNext_s;
            nextData2_s  = mulData2_r;
            nextLink_s   = mulLink_r;
            nextCtl_s    = mulCtl_r;
            nextWreg_s   = mulWreg_r;
         end else begin
            nextCtl_s = 5'd0;
         end
      end else if (accept_s && !isMul_s) begin
`else
      if (accept_s && !isMul_s) begin
`endif
         nextResult_s = aluResult_s;
         nextData2_s  = ReadData2ID;
         nextLink_s   = PCPlus4ID;
         nextCtl_s    = ctlIn_s;
         nextWreg_s   = WriteRegID;
      end else begin
         nextCtl_s = 5'd0;
      end
   end

   // EX/MEM pipeline register and flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ALUResultEx <= 64'd0; RdData2ForMem <= 64'd0; LinkerRegisterDataEX <= 64'd0;
         {LinkerRegEX, MemToRegEX, RegWriteRegisterEX, MemWriteRegisterEX, MemReadRegisterEX} <= 5'd0;
         WriteRegEX <= 5'd0; FlagsEX <= 4'd0;
      end else begin
         ALUResultEx <= nextResult_s; RdData2ForMem <= nextData2_s; LinkerRegisterDataEX <= nextLink_s;
         {LinkerRegEX, MemToRegEX, RegWriteRegisterEX, MemWriteRegisterEX, MemReadRegisterEX} <= nextCtl_s;
         WriteRegEX <= nextWreg_s; FlagsEX <= nextFlags_s;
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage; expected EX/MEM contents are queued at drive time.
module tb_execute_stage;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic [63:0] ReadData1ID, ReadData2ID, ImmID, PCPlus4ID;
   logic        ALUSrcID, SetFlagsID;
   logic [3:0]  ALUOpID;
   logic [5:0]  ShamtID;
   logic        LinkerRegID, MemToRegID, RegWriteID, MemWriteID, MemReadID;
   logic [4:0]  WriteRegID;
   logic        stall_out;
   logic [63:0] ALUResultEx, RdData2ForMem, LinkerRegisterDataEX;
   logic        LinkerRegEX, MemToRegEX, RegWriteRegisterEX, MemWriteRegisterEX, MemReadRegisterEX;
   logic [4:0]  WriteRegEX;
   logic [3:0]  FlagsEX;

   typedef struct {
      logic [63:0] res, d2, link;
      logic [4:0]  ctl, wreg;
      logic [3:0]  flags;
   } exp_t;
   exp_t sbQ[$];

   int checkCnt = 0;
   int passCnt  = 0;
   logic [3:0] flagsModel = 4'd0;

   execute_stage dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
      .ReadData1ID(ReadData1ID), .ReadData2ID(ReadData2ID), .ImmID(ImmID),
      .ALUSrcID(ALUSrcID), .ALUOpID(ALUOpID), .ShamtID(ShamtID), .SetFlagsID(SetFlagsID),
      .PCPlus4ID(PCPlus4ID), .LinkerRegID(LinkerRegID), .MemToRegID(MemToRegID),
      .RegWriteID(RegWriteID), .MemWriteID(MemWriteID), .MemReadID(MemReadID),
      .WriteRegID(WriteRegID), .stall_out(stall_out), .ALUResultEx(ALUResultEx),
      .RdData2ForMem(RdData2ForMem), .LinkerRegisterDataEX(LinkerRegisterDataEX),
      .LinkerRegEX(LinkerRegEX), .MemToRegEX(MemToRegEX), .RegWriteRegisterEX(RegWriteRegisterEX),
      .MemWriteRegisterEX(MemWriteRegisterEX), .MemReadRegisterEX(MemReadRegisterEX),
      .WriteRegEX(WriteRegEX), .FlagsEX(FlagsEX)
   );

   // Free-running pipeline clock.
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCnt++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else passCnt++;
   endtask

   function automatic logic [63:0] refAlu(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input logic [5:0] sh);
      case (op)
         4'd0: return b;
         4'd1: return a + b;
         4'd2: return a - b;
         4'd3: return a & b;
         4'd4: return a | b;
         4'd5: return a ^ b;
         4'd6: return a << sh;
         4'd7: return a >> sh;
         default: return 64'd0;
      endcase
   endfunction

   function automatic logic [3:0] refFlags(input logic isSub, input logic [63:0] a, input logic [63:0] b);
      logic [64:0] u, s;
      logic [63:0] r;
      if (isSub) begin
         r = a - b;
         s = {a[63], a} - {b[63], b};
         return {r[63], r == 64'd0, a >= b, s[64] != s[63]};
      end else begin
         u = {1'b0, a} + {1'b0, b};
         s = {a[63], a} + {b[63], b};
         return {u[63], u[63:0] == 64'd0, u[64], s[64] != s[63]};
      end
   endfunction

   task automatic compareOut(input string tag);
      exp_t e;
      e = sbQ.pop_front();
      checkVal({tag, ".res"},   ALUResultEx, e.res);
      checkVal({tag, ".d2"},    RdData2ForMem, e.d2);
      checkVal({tag, ".link"},  LinkerRegisterDataEX, e.link);
      checkVal({tag, ".ctl"},   {59'd0, LinkerRegEX, MemToRegEX, RegWriteRegisterEX, MemWriteRegisterEX, MemReadRegisterEX}, {59'd0, e.ctl});
      checkVal({tag, ".wreg"},  {59'd0, WriteRegEX}, {59'd0, e.wreg});
      checkVal({tag, ".flags"}, {60'd0, FlagsEX}, {60'd0, e.flags});
      checkVal({tag, ".stall"}, {63'd0, stall_out}, 64'd0);
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [63:0] a, input logic [63:0] r2,
                        input logic [63:0] imm, input logic src, input logic [5:0] sh, input logic sf,
                        input logic [63:0] pc, input logic [4:0] ctl, input logic [4:0] wr);
      in_valid = v; ALUOpID = op; ReadData1ID = a; ReadData2ID = r2; ImmID = imm; ALUSrcID = src;
      ShamtID = sh; SetFlagsID = sf; PCPlus4ID = pc; WriteRegID = wr;
      {LinkerRegID, MemToRegID, RegWriteID, MemWriteID, MemReadID} = ctl;
   endtask

   task automatic step(input string tag, input logic v, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] r2, input logic [63:0] imm, input logic src, input logic [5:0] sh,
                       input logic sf, input logic [63:0] pc, input logic [4:0] ctl, input logic [4:0] wr);
      exp_t e;
      logic [63:0] b;
      drive(v, op, a, r2, imm, src, sh, sf, pc, ctl, wr);
      b = src ? imm : r2;
      if (v && sf && (op == 4'd1 || op == 4'd2)) flagsModel = refFlags(op == 4'd2, a, b);
      if (v) e = '{res: refAlu(op, a, b, sh), d2: r2, link: pc, ctl: ctl, wreg: wr, flags: flagsModel};
      else   e = '{res: 64'd0, d2: 64'd0, link: 64'd0, ctl: 5'd0, wreg: 5'd0, flags: flagsModel};
      sbQ.push_back(e);
      @(posedge clk); #1;
      compareOut(tag);
   endtask

   task automatic checkAllZero(input string tag);
      checkVal({tag, ".res"}, ALUResultEx | RdData2ForMem | LinkerRegisterDataEX, 64'd0);
      checkVal({tag, ".ctl"}, {50'd0, LinkerRegEX, MemToRegEX, RegWriteRegisterEX, MemWriteRegisterEX,
                               MemReadRegisterEX, WriteRegEX, FlagsEX}, 64'd0);
      checkVal({tag, ".stall"}, {63'd0, stall_out}, 64'd0);
   endtask

   initial begin
      reset_n = 1'b1;
      drive(1'b1, 4'd1, 64'h1234, 64'h55, 64'h9, 1'b0, 6'd3, 1'b1, 64'h44, 5'h1f, 5'd7);
      #2 reset_n = 1'b0;
      #1 checkAllZero("reset");
      @(negedge clk); reset_n = 1'b1;

      step("add_ovf", 1'b1, 4'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 6'd0, 1'b1, 64'h10, 5'b00100, 5'd1);
      checkVal("add_ovf.nzcv", {60'd0, FlagsEX}, 64'b1001);
      step("sub_zero", 1'b1, 4'd2, 64'd5, 64'd5, 64'd0, 1'b0, 6'd0, 1'b1, 64'h14, 5'b00100, 5'd2);
      checkVal("sub_zero.nzcv", {60'd0, FlagsEX}, 64'b0110);
      step("store", 1'b1, 4'd1, 64'h100, 64'hDEAD, 64'd8, 1'b1, 6'd0, 1'b0, 64'h18, 5'b00010, 5'd0);
      checkVal("store.addr", ALUResultEx, 64'h108);
      step("bubble", 1'b0, 4'd1, 64'h100, 64'hDEAD, 64'd8, 1'b1, 6'd0, 1'b1, 64'h1c, 5'b11111, 5'd9);
      step("and_nf", 1'b1, 4'd3, 64'hF0F0, 64'hFF00, 64'd0, 1'b0, 6'd0, 1'b1, 64'h20, 5'b00100, 5'd4);
      step("orr", 1'b1, 4'd4, 64'hF0F0, 64'h0F0F, 64'd0, 1'b0, 6'd0, 1'b0, 64'h24, 5'b00100, 5'd5);
      step("eor", 1'b1, 4'd5, 64'hFFFF, 64'd0, 64'h0F0F, 1'b1, 6'd0, 1'b0, 64'h28, 5'b00100, 5'd6);
      step("lsl63", 1'b1, 4'd6, 64'd3, 64'd0, 64'd0, 1'b0, 6'd63, 1'b0, 64'h2c, 5'b10100, 5'd30);
      step("lsr", 1'b1, 4'd7, 64'h8000_0000_0000_0000, 64'd0, 64'd0, 1'b0, 6'd4, 1'b0, 64'h30, 5'b01101, 5'd8);
      step("passb", 1'b1, 4'd0, 64'd1, 64'h77, 64'h99, 1'b1, 6'd0, 1'b0, 64'h34, 5'b00100, 5'd10);
      step("sub_borrow", 1'b1, 4'd2, 64'd1, 64'd2, 64'd0, 1'b0, 6'd0, 1'b1, 64'h38, 5'b00100, 5'd11);
      for (int op = 9; op < 16; op++)
         step("undef", 1'b1, op[3:0], 64'hABCD, 64'h1234, 64'd0, 1'b0, 6'd1, 1'b1, 64'h3c, 5'b00100, 5'd12);
      for (int i = 0; i < 12; i++) begin
         logic [3:0] rop;
         rop = 4'($urandom_range(0, 7));
         step("rand", 1'($urandom), rop, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              1'($urandom), 6'($urandom), 1'($urandom), {$urandom, $urandom}, 5'($urandom), 5'($urandom));
      end

`ifdef EX_MUL_EN
      begin
         int stallCycles = 0;
         drive(1'b1, 4'd8, 64'd123456789, 64'd987654321, 64'd0, 1'b0, 6'd0, 1'b1, 64'h40, 5'b00100, 5'd3);
         @(posedge clk); #1;
         drive(1'b1, 4'd1, 64'd9, 64'd9, 64'd0, 1'b0, 6'd0, 1'b1, 64'h44, 5'b00110, 5'd9);
         for (int c = 0; c < 100; c++) begin
            if (!stall_out) break;
            stallCycles++;
            if (RegWriteRegisterEX !== 1'b0 || FlagsEX !== flagsModel)
               checkVal("mul.wait", {59'd0, RegWriteRegisterEX, FlagsEX}, {60'd0, flagsModel});
            @(posedge clk); #1;
         end
         checkVal("mul.stall_cycles", 64'(stallCycles), 64'd64);
         checkVal("mul.res", ALUResultEx, 64'd121932631112635269);
         checkVal("mul.wreg", {59'd0, WriteRegEX}, 64'd3);
         checkVal("mul.regwrite", {63'd0, RegWriteRegisterEX}, 64'd1);
         checkVal("mul.flags", {60'd0, FlagsEX}, {60'd0, flagsModel});
         step("post_mul", 1'b1, 4'd1, 64'd9, 64'd9, 64'd0, 1'b0, 6'd0, 1'b1, 64'h44, 5'b00110, 5'd9);
         drive(1'b1, 4'd8, 64'd7, 64'd6, 64'd0, 1'b0, 6'd0, 1'b0, 64'h48, 5'b00100, 5'd4);
         @(posedge clk); #1;
         drive(1'b0, 4'd0, 64'd0, 64'd0, 64'd0, 1'b0, 6'd0, 1'b0, 64'd0, 5'd0, 5'd0);
         repeat (30) @(posedge clk);
         #1 checkVal("mulabort.stall_pre", {63'd0, stall_out}, 64'd1);
      end
`else
      step("mul_undef", 1'b1, 4'd8, 64'd123456789, 64'd987654321, 64'd0, 1'b0, 6'd0, 1'b1, 64'h40, 5'b00100, 5'd3);
      for (int c = 0; c < 3; c++)
         step("mul_after", 1'b0, 4'd0, 64'd0, 64'd0, 64'd0, 1'b0, 6'd0, 1'b0, 64'd0, 5'd0, 5'd0);
`endif

      reset_n = 1'b0;
      #1 checkAllZero("midreset");
      flagsModel = 4'd0;
      sbQ.delete();
      #2 reset_n = 1'b1;
      step("add_after_rst", 1'b1, 4'd1, 64'd2, 64'd3, 64'd0, 1'b0, 6'd0, 1'b0, 64'h50, 5'b00100, 5'd5);
      checkVal("add_after_rst.five", ALUResultEx, 64'd5);
      step("drain", 1'b0, 4'd0, 64'd0, 64'd0, 64'd0, 1'b0, 6'd0, 1'b0, 64'd0, 5'd0, 5'd0);

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end
endmodule
